// File: rtl/mem_reader_pkg.sv
// Shared definitions for mem_reader: address-width helper and FSM state encoding.
package mem_reader_pkg;

  // Ceiling log2 of a positive integer. This is used to size the address
  // pointer from the RAM depth.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEFAULT_BUFFER_SIZE = 1024;
  localparam int DEFAULT_ADDR_W      = log2(DEFAULT_BUFFER_SIZE);

  // Each token takes four states: CHECK, RD_RAM, WAIT_RAM and WR_FIFO.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_RD_RAM   = 3'd2,
    ST_WAIT_RAM = 3'd3,
    ST_WR_FIFO  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/mem_reader.sv
// mem_reader: streams num_tokens words from a synchronous RAM, starting at
// base_addr, into a downstream FIFO. It reads one word per RAM access and
// stalls while the FIFO reports full.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter  int word_size   = 16,
  parameter  int buffer_size = DEFAULT_BUFFER_SIZE,
  localparam int ADDR_W      = log2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      num_tokens,
  input  logic [ADDR_W:0]      FIFO_population,
  input  logic [word_size-1:0] ram_rd_data,
  output logic                 ram_rd_en,
  output logic [ADDR_W-1:0]    ram_rd_addr,
  output logic                 FIFO_wr_en,
  output logic [word_size-1:0] output_token,
  output logic                 busy,
  output logic                 done_out
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_W-1:0]      r_ptr;
  logic [ADDR_W:0]        r_remaining;
  logic [word_size-1:0]   r_token;

  logic                   w_accept;
  logic                   w_fifo_full;
  logic                   w_last;
  logic                   w_rd_en;
  logic                   w_wr_en;
  logic                   w_busy;
  logic                   w_done;

  // The FIFO is full only at exactly buffer_size. One slot free still allows a write.
  assign w_fifo_full = (FIFO_population == (ADDR_W+1)'(buffer_size));
  assign w_accept    = (r_state == ST_IDLE) && start_in;
  assign w_last      = (r_remaining == (ADDR_W+1)'(1));

  // State register. Reset abandons any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Address pointer and remaining count. These are loaded on start and stepped once per FIFO write.
  // The pointer wraps naturally because buffer_size is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_ptr       <= base_addr;
      r_remaining <= num_tokens;
    end else if (r_state == ST_WR_FIFO) begin
      r_ptr       <= r_ptr + ADDR_W'(1);
      r_remaining <= r_remaining - (ADDR_W+1)'(1);
    end
  end

  // Capture the RAM word in the cycle after the read strobe. The word is held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_token <= '0;
    else if (r_state == ST_WAIT_RAM) r_token <= ram_rd_data;
  end

  // Next-state logic and Moore output decode
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start_in) begin
          if (num_tokens == '0) w_next_state = ST_DONE;
          else                  w_next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!w_fifo_full) w_next_state = ST_RD_RAM;
      end
      ST_RD_RAM: begin
        w_rd_en      = 1'b1;
        w_next_state = ST_WAIT_RAM;
      end
      ST_WAIT_RAM: begin
        w_next_state = ST_WR_FIFO;
      end
      ST_WR_FIFO: begin
        w_wr_en = 1'b1;
        if (w_last) w_next_state = ST_DONE;
        else        w_next_state = ST_CHECK;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign ram_rd_en    = w_rd_en;
  assign ram_rd_addr  = r_ptr;
  assign FIFO_wr_en   = w_wr_en;
  assign output_token = r_token;
  assign busy         = w_busy;
  assign done_out     = w_done;

endmodule
